// File: rtl/mealy_seq_tx.sv
// mealy_seq_tx: queues 3-bit words and sends them MSB first in aligned 3-bit frames, idle 000 when empty.
// Accept-to-first-bit 1..3 cycles; in_ready low only when FIFO full; SEQ_TX_ZPRED_EN adds expected_z.
module seq_tx_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign full   = (cnt == FULL_CNT);
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld & ~full;
  assign pop    = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module mealy_seq_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          x_out,
  output logic                          frame_start,
  output logic                          frame_is_data,
  output logic                          expected_z,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              frames_sent
);
  typedef enum logic [1:0] {
    PH_B0  = 2'd0,
    PH_B1  = 2'd1,
    PH_B2  = 2'd2,
    PH_BAD = 2'd3
  } phase_t;

  phase_t           phase_q, phase_nxt;
  logic [2:0]       sr_q, sr_nxt;
  logic             data_q, data_nxt;
  logic [CNT_W-1:0] frames_q, frames_nxt;
  logic             pop;
  logic             frame_done;
  logic             push;
  logic             full;
  logic             empty;
  logic [2:0]       head;

  assign in_ready = ~full;
  assign push     = in_valid & ~full;

  seq_tx_fifo #(.W(3), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat (in_data),
    .rd_en  (pop),
    .rd_dat (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count)
  );

  always_comb begin
    phase_nxt  = phase_q;
    sr_nxt     = sr_q;
    data_nxt   = data_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (phase_q)
      PH_B0: begin
        phase_nxt = PH_B1;
        sr_nxt    = {sr_q[1:0], 1'b0};
      end
      PH_B1: begin
        phase_nxt = PH_B2;
        sr_nxt    = {sr_q[1:0], 1'b0};
      end
      PH_B2: begin
        // Frame boundary: the head word (if any) becomes the next frame.
        phase_nxt  = PH_B0;
        frame_done = data_q;
        if (!empty) begin
          pop      = 1'b1;
          sr_nxt   = head;
          data_nxt = 1'b1;
        end else begin
          sr_nxt   = 3'b000;
          data_nxt = 1'b0;
        end
      end
      default: phase_nxt = PH_B0;
    endcase
    frames_nxt = frames_q + CNT_W'(frame_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_B0;
      sr_q     <= 3'b000;
      data_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      phase_q  <= phase_nxt;
      sr_q     <= sr_nxt;
      data_q   <= data_nxt;
      frames_q <= frames_nxt;
    end
  end

`ifdef SEQ_TX_ZPRED_EN
  logic par_q, par_nxt;
  logic ez_q, ez_nxt;

  // Parity is captured at load time since sr shifts the word away.
  always_comb begin
    par_nxt = pop ? ^head : par_q;
    ez_nxt  = (phase_q == PH_B1) & data_q & par_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      ez_q  <= 1'b0;
    end else begin
      par_q <= par_nxt;
      ez_q  <= ez_nxt;
    end
  end

  assign expected_z = ez_q;
`else
  assign expected_z = 1'b0;
`endif

  assign x_out         = sr_q[2];
  assign frame_start   = (phase_q == PH_B0);
  assign frame_is_data = data_q;
  assign frames_sent   = frames_q;
endmodule

// File: tb/tb_mealy_seq_tx.sv
// Bench for mealy_seq_tx: directed and random stimulus against a frame-level queue model.
module tb_mealy_seq_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_data = 3'b000;
  logic       in_valid = 1'b0;
  logic       in_ready, x_out, frame_start, frame_is_data, expected_z;
  logic [2:0] fifo_count;
  logic [7:0] frames_sent;

  int tests = 0;
  int fails = 0;

  // Model: queued words, word in flight, bit index within frame, data flag, sent count.
  logic [2:0] q[$];
  int         idx = 0;
  logic [2:0] word = 3'b000;
  logic       data = 1'b0;
  int         fs = 0;

  always #5 clk = ~clk;

  mealy_seq_tx #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .x_out         (x_out),
    .frame_start   (frame_start),
    .frame_is_data (frame_is_data),
    .expected_z    (expected_z),
    .fifo_count    (fifo_count),
    .frames_sent   (frames_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] w;
    logic       ez;
    w = word;
`ifdef SEQ_TX_ZPRED_EN
    ez = data && (idx == 2) && (w == 3'b001 || w == 3'b010 || w == 3'b100 || w == 3'b111);
`else
    ez = 1'b0;
`endif
    chk("x_out",         32'(x_out),         32'((w >> (2 - idx)) & 3'b001));
    chk("frame_start",   32'(frame_start),   32'(idx == 0));
    chk("frame_is_data", 32'(frame_is_data), 32'(data));
    chk("fifo_count",    32'(fifo_count),    32'(q.size()));
    chk("in_ready",      32'(in_ready),      32'(q.size() < 4));
    chk("frames_sent",   32'(frames_sent),   32'(fs % 256));
    chk("expected_z",    32'(expected_z),    32'(ez));
  endtask

  // One clock: inputs already driven; update model at the edge, compare at the falling edge.
  task automatic cycle();
    bit acc;
    acc = in_valid && !rst && (q.size() < 4);
    @(posedge clk);
    if (rst) begin
      q.delete();
      idx  = 0;
      word = 3'b000;
      data = 1'b0;
      fs   = 0;
    end else begin
      if (idx == 2) begin
        if (data) fs++;
        if (q.size() > 0) begin
          word = q.pop_front();
          data = 1'b1;
        end else begin
          word = 3'b000;
          data = 1'b0;
        end
        idx = 0;
      end else begin
        idx++;
      end
      if (acc) q.push_back(in_data);
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [2:0] burst [5];
    int k;
    bit ok;
    burst[0] = 3'b001; burst[1] = 3'b011; burst[2] = 3'b111;
    burst[3] = 3'b000; burst[4] = 3'b110;

    // Reset then idle frames.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) cycle();

    // Single word pushed during phase 1.
    cycle();
    in_valid = 1'b1; in_data = 3'b101;
    cycle();
    in_valid = 1'b0; in_data = 3'b010;
    for (int c = 0; c < 8; c++) cycle();
    chk("single_frames_sent", 32'(frames_sent), 32'd1);

    // Five words with valid held until each is taken; FIFO fills then drains.
    k = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 5);
      in_data  = (k < 5) ? burst[k] : 3'b000;
      ok = in_valid && (q.size() < 4);
      cycle();
      if (ok) k++;
    end
    in_valid = 1'b0;
    chk("burst_all_accepted", 32'(k), 32'd5);

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 3'($urandom_range(0, 7));
      cycle();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) cycle();

    // Reset during phase 1 of a data frame with two words queued.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 3'($urandom_range(1, 7));
      cycle();
    end
    in_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if (idx == 1 && data && q.size() == 2) ok = 1'b1;
      else cycle();
    end
    chk("rst_setup_reached", 32'(ok), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_mid_frame_start", 32'(frame_start), 32'd1);
    for (int c = 0; c < 3; c++) cycle();

    // Push on the phase-2 edge with an empty FIFO: no bypass.
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      if (idx == 2 && q.size() == 0) ok = 1'b1;
      else cycle();
    end
    chk("nobypass_setup_reached", 32'(ok), 32'd1);
    in_valid = 1'b1; in_data = 3'b111;
    cycle();
    in_valid = 1'b0;
    chk("nobypass_idle_frame", 32'(frame_is_data), 32'd0);
    for (int c = 0; c < 3; c++) cycle();
    chk("nobypass_word_frame", 32'(frame_is_data), 32'd1);
    for (int c = 0; c < 6; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
